// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU byte-stream command sequencer.
// Holds the state encoding, opcode values, guard result values and opcode helpers.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_A   = 3'd1,
        ST_GET_B   = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND_HI = 3'd4,
        ST_SEND_LO = 3'd5
    } seq_state_e;

    localparam logic [7:0] OP_NOP = 8'd0;
    localparam logic [7:0] OP_ADD = 8'd1;
    localparam logic [7:0] OP_SUB = 8'd2;
    localparam logic [7:0] OP_MUL = 8'd3;
    localparam logic [7:0] OP_DIV = 8'd4;
    localparam logic [7:0] OP_MOD = 8'd5;

    localparam logic [15:0] ERR_DIVZERO_VAL = 16'hFFFF;
    localparam logic [15:0] ERR_BADOP_VAL   = 16'h0000;

    function automatic logic op_is_valid(input logic [7:0] op);
        return (op >= OP_ADD) && (op <= OP_MOD);
    endfunction

    function automatic logic op_is_divide(input logic [7:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_cmd_timer.sv
// Inter-byte idle timer: counts idle cycles while a command is partially received
// and strobes expire on the idle cycle that exhausts the TIMEOUT_CYCLES allowance.
module alu_cmd_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expire
);

    localparam logic ENABLED = (TIMEOUT_CYCLES != 32'd0);
    localparam logic [TO_W-1:0] LAST_IDLE =
        TO_W'((TIMEOUT_CYCLES > 32'd0) ? (TIMEOUT_CYCLES - 32'd1) : 32'd0);
    localparam logic [TO_W-1:0] ONE = {{(TO_W-1){1'b0}}, 1'b1};

    logic [TO_W-1:0] count_r;

    // Idle-cycle counter; cleared on traffic or outside the receive states.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (tick && ENABLED) begin
            count_r <= count_r + ONE;
        end else begin
            count_r <= count_r;
        end
    end

    // The current idle cycle is the last one allowed: abort at this edge.
    always_comb begin
        expire = 1'b0;
        if (ENABLED && tick && !clear && (count_r == LAST_IDLE)) begin
            expire = 1'b1;
        end else begin
            expire = 1'b0;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Byte-stream front end for the 8-bit ALU: collects opcode/A/B, drives the ALU
// from registers, guards bad opcodes and divide-by-zero, streams the result out.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  alu_data1,
    output logic [7:0]  alu_data2,
    output logic [7:0]  alu_control,
    input  logic [15:0] alu_result,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        out_err,
    output logic        busy,
    output logic        timeout_pulse
);

    seq_state_e  state_r;
    seq_state_e  state_next_s;

    logic [7:0]  alu_control_r;
    logic [7:0]  alu_data1_r;
    logic [7:0]  alu_data2_r;
    logic [15:0] result_r;
    logic        err_r;

    logic        in_ready_r;
    logic [7:0]  out_data_r;
    logic        out_valid_r;
    logic        out_last_r;
    logic        out_err_r;
    logic        busy_r;
    logic        timeout_pulse_r;

    logic        xfer_s;
    logic        accept_s;
    logic        receiving_s;
    logic        expire_s;
    logic        abort_s;
    logic [15:0] res_calc_s;
    logic        err_calc_s;
    logic [15:0] res_next_s;
    logic        err_next_s;

    assign xfer_s      = in_valid && in_ready_r;
    assign accept_s    = out_valid_r && out_ready;
    assign receiving_s = (state_r == ST_GET_A) || (state_r == ST_GET_B);

    alu_cmd_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (xfer_s || !receiving_s),
        .tick   (receiving_s && !xfer_s),
        .expire (expire_s)
    );

    // Next-state logic for the command FSM.
    always_comb begin
        state_next_s = state_r;
        abort_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s) state_next_s = ST_GET_A;
                else        state_next_s = ST_IDLE;
            end
            ST_GET_A: begin
                if (xfer_s) begin
                    state_next_s = ST_GET_B;
                end else if (expire_s) begin
                    state_next_s = ST_IDLE;
                    abort_s      = 1'b1;
                end else begin
                    state_next_s = ST_GET_A;
                end
            end
            ST_GET_B: begin
                if (xfer_s) begin
                    state_next_s = ST_EXEC;
                end else if (expire_s) begin
                    state_next_s = ST_IDLE;
                    abort_s      = 1'b1;
                end else begin
                    state_next_s = ST_GET_B;
                end
            end
            ST_EXEC: begin
                state_next_s = ST_SEND_HI;
            end
            ST_SEND_HI: begin
                if (accept_s) state_next_s = ST_SEND_LO;
                else          state_next_s = ST_SEND_HI;
            end
            ST_SEND_LO: begin
                if (accept_s) state_next_s = ST_IDLE;
                else          state_next_s = ST_SEND_LO;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Guarded result: the ALU output is only trusted for defined operations.
    always_comb begin
        res_calc_s = alu_result;
        err_calc_s = 1'b0;
        if (!op_is_valid(alu_control_r)) begin
            res_calc_s = ERR_BADOP_VAL;
            err_calc_s = 1'b1;
        end else if (op_is_divide(alu_control_r) && (alu_data2_r == 8'h00)) begin
            res_calc_s = ERR_DIVZERO_VAL;
            err_calc_s = 1'b1;
        end else begin
            res_calc_s = alu_result;
            err_calc_s = 1'b0;
        end
    end

    // Result as it will be after this edge, so output bytes can be registered.
    always_comb begin
        res_next_s = result_r;
        err_next_s = err_r;
        if (state_r == ST_EXEC) begin
            res_next_s = res_calc_s;
            err_next_s = err_calc_s;
        end else begin
            res_next_s = result_r;
            err_next_s = err_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= state_next_s;
    end

    // Command capture and result registers; ALU inputs hold until overwritten.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_control_r <= 8'h00;
            alu_data1_r   <= 8'h00;
            alu_data2_r   <= 8'h00;
            result_r      <= 16'h0000;
            err_r         <= 1'b0;
        end else begin
            if (xfer_s && (state_r == ST_IDLE))  alu_control_r <= in_data;
            else                                 alu_control_r <= alu_control_r;
            if (xfer_s && (state_r == ST_GET_A)) alu_data1_r <= in_data;
            else                                 alu_data1_r <= alu_data1_r;
            if (xfer_s && (state_r == ST_GET_B)) alu_data2_r <= in_data;
            else                                 alu_data2_r <= alu_data2_r;
            result_r <= res_next_s;
            err_r    <= err_next_s;
        end
    end

    // Handshake and stream outputs, registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready_r      <= 1'b0;
            out_data_r      <= 8'h00;
            out_valid_r     <= 1'b0;
            out_last_r      <= 1'b0;
            out_err_r       <= 1'b0;
            busy_r          <= 1'b0;
            timeout_pulse_r <= 1'b0;
        end else begin
            in_ready_r      <= (state_next_s == ST_IDLE) || (state_next_s == ST_GET_A) ||
                               (state_next_s == ST_GET_B);
            out_valid_r     <= (state_next_s == ST_SEND_HI) || (state_next_s == ST_SEND_LO);
            out_last_r      <= (state_next_s == ST_SEND_LO);
            busy_r          <= (state_next_s != ST_IDLE);
            timeout_pulse_r <= abort_s;
            case (state_next_s)
                ST_SEND_HI: begin
                    out_data_r <= res_next_s[15:8];
                    out_err_r  <= err_next_s;
                end
                ST_SEND_LO: begin
                    out_data_r <= res_next_s[7:0];
                    out_err_r  <= err_next_s;
                end
                default: begin
                    out_data_r <= 8'h00;
                    out_err_r  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_r;
    assign alu_control   = alu_control_r;
    assign alu_data1     = alu_data1_r;
    assign alu_data2     = alu_data2_r;
    assign out_data      = out_data_r;
    assign out_valid     = out_valid_r;
    assign out_last      = out_last_r;
    assign out_err       = out_err_r;
    assign busy          = busy_r;
    assign timeout_pulse = timeout_pulse_r;

endmodule
